bids22_round_ctrl: RTL

Round sequencer for the bids22 auction engine. Accepts one round descriptor from the host (bidder balances, bidder mask, round length), drives the engine's control-op port to configure it, holds the start strobe for the requested length, waits for round completion and returns winner, max bid and error status. Sits between the host/testbench command layer and the engine's `C_op`/`C_data`/`C_start` inputs; it is the only driver of those inputs.

---
 rtl/bids22_round_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/bids22_round_ctrl.sv
// bids22 round sequencer: configures the auction engine, runs one round, reports.
// Optional watchdog on ISSUE stalls and WAIT: define BIDS22_ROUND_TIMEOUT_EN.
module bids22_round_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_bal_x,
  input  logic [31:0] req_bal_y,
  input  logic [31:0] req_bal_z,
  input  logic [2:0]  req_mask,
  input  logic [15:0] req_len,
  input  logic        eng_ready,
  input  logic [2:0]  eng_err,
  input  logic        eng_round_over,
  input  logic        eng_x_win,
  input  logic        eng_y_win,
  input  logic        eng_z_win,
  input  logic [31:0] eng_max_bid,
  output logic [3:0]  eng_op,
  output logic [31:0] eng_data,
  output logic        eng_start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  res_winner,
  output logic [31:0] res_max_bid,
  output logic [2:0]  res_err,
  output logic        res_timeout
);
  localparam logic [3:0] OP_UNLOCK   = 4'h1;
  localparam logic [3:0] OP_LOCK     = 4'h2;
  localparam logic [3:0] OP_LOAD_X   = 4'h3;
  localparam logic [3:0] OP_LOAD_Y   = 4'h4;
  localparam logic [3:0] OP_LOAD_Z   = 4'h5;
  localparam logic [3:0] OP_SET_MASK = 4'h6;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CHECK, S_RUN, S_WAIT, S_REPORT
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] bal_x_q, bal_x_d;
  logic [31:0] bal_y_q, bal_y_d;
  logic [31:0] bal_z_q, bal_z_d;
  logic [2:0]  mask_q, mask_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  win_q, win_d;
  logic [31:0] max_q, max_d;
  logic [2:0]  err_q, err_d;
  logic        tout_q, tout_d;
  logic [3:0]  cur_op;
  logic [31:0] cur_data;
  logic [1:0]  cap_win;
  logic [2:0]  cap_err;

`ifdef BIDS22_ROUND_TIMEOUT_EN
  localparam int TIMEOUT = 1024;
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_REPORT);
  assign res_winner  = win_q;
  assign res_max_bid = max_q;
  assign res_err     = err_q;
  assign res_timeout = tout_q;

  always_comb begin
    cur_op   = OP_UNLOCK;
    cur_data = '0;
    case (idx_q)
      3'd1:    begin cur_op = OP_LOAD_X; cur_data = bal_x_q; end
      3'd2:    begin cur_op = OP_LOAD_Y; cur_data = bal_y_q; end
      3'd3:    begin cur_op = OP_LOAD_Z; cur_data = bal_z_q; end
      3'd4:    begin cur_op = OP_SET_MASK; cur_data = {29'b0, mask_q}; end
      3'd5:    cur_op = OP_LOCK;
      default: cur_op = OP_UNLOCK;
    endcase
  end

  // More than one win flag is an engine inconsistency, reported as err 7.
  always_comb begin
    cap_win = 2'd0;
    cap_err = 3'h0;
    case ({eng_z_win, eng_y_win, eng_x_win})
      3'b000:  cap_win = 2'd0;
      3'b001:  cap_win = 2'd1;
      3'b010:  cap_win = 2'd2;
      3'b100:  cap_win = 2'd3;
      default: cap_err = 3'h7;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bal_x_d   = bal_x_q;
    bal_y_d   = bal_y_q;
    bal_z_d   = bal_z_q;
    mask_d    = mask_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    max_d     = max_q;
    err_d     = err_q;
    tout_d    = tout_q;
    eng_op    = 4'h0;
    eng_data  = 32'h0;
    eng_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          bal_x_d = req_bal_x;
          bal_y_d = req_bal_y;
          bal_z_d = req_bal_z;
          mask_d  = req_mask;
          len_d   = (req_len == 16'd0) ? 16'd1 : req_len;
          idx_d   = 3'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (eng_ready) begin
          eng_op   = cur_op;
          eng_data = cur_data;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (eng_err != 3'h0) begin
          err_d   = eng_err;
          win_d   = 2'd0;
          max_d   = 32'h0;
          tout_d  = 1'b0;
          state_d = S_REPORT;
        end else if (idx_q == 3'd5) begin
          cnt_d   = len_q;
          state_d = S_RUN;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_RUN: begin
        if (eng_round_over) begin
          win_d   = cap_win;
          err_d   = cap_err;
          max_d   = eng_max_bid;
          tout_d  = 1'b0;
          state_d = S_REPORT;
        end else begin
          eng_start = 1'b1;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_round_over) begin
          win_d   = cap_win;
          err_d   = cap_err;
          max_d   = eng_max_bid;
          tout_d  = 1'b0;
          state_d = S_REPORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef BIDS22_ROUND_TIMEOUT_EN
    tmo_d = '0;
    if (state_d == state_q &&
        ((state_q == S_ISSUE && !eng_ready) || state_q == S_WAIT)) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d   = S_REPORT;
        tout_d    = 1'b1;
        err_d     = 3'h7;
        win_d     = 2'd0;
        max_d     = 32'h0;
        eng_start = 1'b0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      bal_x_q <= 32'h0;
      bal_y_q <= 32'h0;
      bal_z_q <= 32'h0;
      mask_q  <= 3'h0;
      len_q   <= 16'h0;
      cnt_q   <= 16'h0;
      win_q   <= 2'd0;
      max_q   <= 32'h0;
      err_q   <= 3'h0;
      tout_q  <= 1'b0;
`ifdef BIDS22_ROUND_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bal_x_q <= bal_x_d;
      bal_y_q <= bal_y_d;
      bal_z_q <= bal_z_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      max_q   <= max_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
`ifdef BIDS22_ROUND_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end
endmodule
